// File: rtl/methane_pkg.sv
// Shared register-file sizing defaults and an index-width helper.
package methane_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREG_DEFAULT  = 32;
  localparam int IDX_W_DEFAULT = $clog2(NREG_DEFAULT);

  // Index width for a register file of n entries; at least one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per register, with flush, writeback clear and
// reserve applied in that order; per-port registered busy lookup.
module reg_scoreboard
  import methane_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  parameter int NRD  = 2,
  localparam int AW  = idx_width(NREG)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic [AW-1:0]     clr_addr,
  input  logic              set,
  input  logic [AW-1:0]     set_addr,
  input  logic              flush,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD-1:0]    rbusy
);

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_cleared;
  logic [NREG-1:0] busy_next;
  logic [NRD-1:0]  rbusy_reg;
  logic [NRD-1:0]  rbusy_next;

  // Reads observe the state after clears but before this cycle's reserve.
  always_comb begin
    busy_cleared = flush ? '0 : busy_reg;
    if (clr) busy_cleared[clr_addr] = 1'b0;
    busy_next = busy_cleared;
    if (set) busy_next[set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    assign rbusy_next[gi] = busy_cleared[raddr[gi*AW +: AW]];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_reg  <= '0;
      rbusy_reg <= '0;
    end else begin
      busy_reg  <= busy_next;
      rbusy_reg <= rbusy_next;
    end
  end

  assign rbusy = rbusy_reg;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with hardwired-zero x0, write-first bypass and a
// busy-bit scoreboard for issue hazard detection.
module reg_file_sb
  import methane_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int NRD  = 2,
  localparam int AW  = idx_width(NREG)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                wclr,
  input  logic                rsv,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                flush,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  output logic                hazard
);

  logic [XLEN-1:0]   mem_reg [NREG];
  logic [XLEN-1:0]   rdata_next [NRD];
  logic [NRD*XLEN-1:0] rdata_reg;
  logic              wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) mem_reg[i] <= '0;
    end else if (wr_en) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // x0 reads as zero regardless of storage or a same-cycle write to it.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] rd_addr;
    assign rd_addr = raddr[gi*AW +: AW];
    assign rdata_next[gi] = (rd_addr == '0)               ? '0    :
                            (wr_en && (waddr == rd_addr)) ? wdata :
                                                            mem_reg[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata_reg <= '0;
    end else begin
      for (int i = 0; i < NRD; i++) rdata_reg[i*XLEN +: XLEN] <= rdata_next[i];
    end
  end

  assign rdata = rdata_reg;

  reg_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD)
  ) u_scoreboard (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (wclr),
    .clr_addr (waddr),
    .set      (rsv),
    .set_addr (rsv_addr),
    .flush    (flush),
    .raddr    (raddr),
    .rbusy    (rbusy)
  );

  assign hazard = |rbusy;

endmodule
